// File: rtl/branch_train_queue_pkg.sv
// Shared widths and the entry payload layout for the branch training queue.
package branch_train_queue_pkg;

  localparam int unsigned HW               = 7;
  localparam int unsigned BQ_DEPTH_DEFAULT = 8;

  typedef struct packed {
    logic [HW-1:0] pc;
    logic [HW-1:0] hist;
    logic          pred;
    logic          gpred;
    logic          lpred;
  } bq_entry_t;

  // Training "taken" bits report whether the prediction matched the outcome.
  function automatic logic is_correct(input logic pred, input logic actual);
    return pred == actual;
  endfunction

endpackage

// File: rtl/bq_entry_ram.sv
// Per-entry prediction payload: one write port, async reads for head and resolve tag.
module bq_entry_ram
  import branch_train_queue_pkg::*;
#(
  parameter int unsigned DEPTH = BQ_DEPTH_DEFAULT,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  bq_entry_t     i_wdata,
  input  logic [AW-1:0] i_raddr_a,
  output bq_entry_t     o_rdata_a,
  input  logic [AW-1:0] i_raddr_b,
  output logic [HW-1:0] o_hist_b,
  output logic          o_pred_b
);

  bq_entry_t r_mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Resolve side only needs the history and final prediction.
  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_hist_b  = r_mem[i_raddr_b].hist;
  assign o_pred_b  = r_mem[i_raddr_b].pred;

endmodule

// File: rtl/branch_train_queue.sv
// In-flight branch queue: allocates at fetch, resolves out of order, trains in order.
module branch_train_queue
  import branch_train_queue_pkg::*;
#(
  parameter int unsigned DEPTH = BQ_DEPTH_DEFAULT,
  parameter int unsigned TW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          F_alloc_valid_i,
  input  logic [HW-1:0] F_PC_i,
  input  logic [HW-1:0] F_global_history_i,
  input  logic          F_predict_i,
  input  logic          F_global_predict_i,
  input  logic          F_local_predict_i,
  output logic          F_alloc_ready_o,
  output logic [TW-1:0] F_tag_o,
  input  logic          E_resolve_valid_i,
  input  logic [TW-1:0] E_tag_i,
  input  logic          E_actual_taken_i,
  output logic          ED_train_valid_o,
  output logic [HW-1:0] ED_train_global_history_o,
  output logic          ED_train_global_predict_o,
  output logic          ED_train_global_taken_o,
  output logic          MD_train_valid_o,
  output logic [HW-1:0] MD_PC_o,
  output logic [HW-1:0] MD_train_global_history_o,
  output logic          MD_train_predict_o,
  output logic          MD_train_taken_o,
  output logic          MD_train_global_predict_o,
  output logic          MD_train_global_taken_o,
  output logic          MD_train_local_predict_o,
  output logic          MD_train_local_taken_o
);

  localparam int unsigned CW = TW + 1;

  logic [DEPTH-1:0] r_valid, r_resolved, r_actual;
  logic [TW-1:0]    r_head, r_tail;
  logic [CW-1:0]    r_count;

  logic [DEPTH-1:0] w_valid_nxt, w_resolved_nxt, w_actual_nxt;
  logic [TW-1:0]    w_head_nxt, w_tail_nxt, w_res_dist, w_dist_i;
  logic [CW-1:0]    w_count_nxt;
  logic             w_res_ok, w_mis, w_alloc, w_commit, w_res_pred;
  logic [HW-1:0]    w_res_hist;
  bq_entry_t        w_wdata, w_head_entry;

  assign F_alloc_ready_o = (r_count != CW'(DEPTH));
  assign F_tag_o         = r_tail;

  assign w_wdata = '{pc: F_PC_i, hist: F_global_history_i, pred: F_predict_i,
                     gpred: F_global_predict_i, lpred: F_local_predict_i};

  bq_entry_ram #(.DEPTH(DEPTH), .AW(TW)) u_ram (
    .clk_i     (clk_i),
    .i_we      (w_alloc),
    .i_waddr   (r_tail),
    .i_wdata   (w_wdata),
    .i_raddr_a (r_head),
    .o_rdata_a (w_head_entry),
    .i_raddr_b (E_tag_i),
    .o_hist_b  (w_res_hist),
    .o_pred_b  (w_res_pred)
  );

  // A mispredict squashes the fetch-side allocation of the same cycle.
  assign w_res_ok   = E_resolve_valid_i & r_valid[E_tag_i] & ~r_resolved[E_tag_i] & ~flush_i;
  assign w_mis      = w_res_ok & (w_res_pred != E_actual_taken_i);
  assign w_alloc    = F_alloc_valid_i & F_alloc_ready_o & ~w_mis & ~flush_i;
  assign w_commit   = r_valid[r_head] & r_resolved[r_head] & ~flush_i;
  assign w_res_dist = E_tag_i - r_head;

  always_comb begin
    w_valid_nxt    = r_valid;
    w_resolved_nxt = r_resolved;
    w_actual_nxt   = r_actual;
    w_head_nxt     = r_head;
    w_tail_nxt     = r_tail;
    w_count_nxt    = r_count;
    w_dist_i       = '0;
    if (flush_i) begin
      w_valid_nxt    = '0;
      w_resolved_nxt = '0;
      w_head_nxt     = '0;
      w_tail_nxt     = '0;
      w_count_nxt    = '0;
    end else begin
      if (w_commit) begin
        w_valid_nxt[r_head]    = 1'b0;
        w_resolved_nxt[r_head] = 1'b0;
        w_head_nxt             = r_head + TW'(1);
      end
      if (w_res_ok) begin
        w_resolved_nxt[E_tag_i] = 1'b1;
        w_actual_nxt[E_tag_i]   = E_actual_taken_i;
      end
      if (w_mis) begin
        // Everything older than head-relative distance of the resolving tag survives.
        for (int i = 0; i < int'(DEPTH); i++) begin
          w_dist_i = TW'(i) - r_head;
          if (w_dist_i > w_res_dist) begin
            w_valid_nxt[i]    = 1'b0;
            w_resolved_nxt[i] = 1'b0;
          end
        end
        w_tail_nxt  = E_tag_i + TW'(1);
        w_count_nxt = CW'(w_res_dist) + CW'(1) - CW'(w_commit);
      end else begin
        w_count_nxt = r_count + CW'(w_alloc) - CW'(w_commit);
      end
      if (w_alloc) begin
        w_valid_nxt[r_tail]    = 1'b1;
        w_resolved_nxt[r_tail] = 1'b0;
        w_tail_nxt             = r_tail + TW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      r_valid                   <= '0;
      r_resolved                <= '0;
      r_actual                  <= '0;
      r_head                    <= '0;
      r_tail                    <= '0;
      r_count                   <= '0;
      ED_train_valid_o          <= 1'b0;
      ED_train_global_history_o <= '0;
      ED_train_global_predict_o <= 1'b0;
      ED_train_global_taken_o   <= 1'b0;
      MD_train_valid_o          <= 1'b0;
      MD_PC_o                   <= '0;
      MD_train_global_history_o <= '0;
      MD_train_predict_o        <= 1'b0;
      MD_train_taken_o          <= 1'b0;
      MD_train_global_predict_o <= 1'b0;
      MD_train_global_taken_o   <= 1'b0;
      MD_train_local_predict_o  <= 1'b0;
      MD_train_local_taken_o    <= 1'b0;
    end else begin
      r_valid          <= w_valid_nxt;
      r_resolved       <= w_resolved_nxt;
      r_actual         <= w_actual_nxt;
      r_head           <= w_head_nxt;
      r_tail           <= w_tail_nxt;
      r_count          <= w_count_nxt;
      ED_train_valid_o <= w_res_ok;
      MD_train_valid_o <= w_commit;
      if (w_res_ok) begin
        ED_train_global_history_o <= w_res_hist;
        ED_train_global_predict_o <= w_res_pred;
        ED_train_global_taken_o   <= is_correct(w_res_pred, E_actual_taken_i);
      end
      if (w_commit) begin
        MD_PC_o                   <= w_head_entry.pc;
        MD_train_global_history_o <= w_head_entry.hist;
        MD_train_predict_o        <= w_head_entry.pred;
        MD_train_taken_o          <= is_correct(w_head_entry.pred, r_actual[r_head]);
        MD_train_global_predict_o <= w_head_entry.gpred;
        MD_train_global_taken_o   <= is_correct(w_head_entry.gpred, r_actual[r_head]);
        MD_train_local_predict_o  <= w_head_entry.lpred;
        MD_train_local_taken_o    <= is_correct(w_head_entry.lpred, r_actual[r_head]);
      end
    end
  end

endmodule

// File: tb/tb_branch_train_queue.sv
// Directed bench for branch_train_queue: one hand-written training sequence plus a cycle table.
module tb_branch_train_queue;

  logic       clk_i = 1'b0;
  logic       rst, flush_i;
  logic       F_alloc_valid_i, F_predict_i, F_global_predict_i, F_local_predict_i;
  logic [6:0] F_PC_i, F_global_history_i;
  logic       F_alloc_ready_o;
  logic [2:0] F_tag_o;
  logic       E_resolve_valid_i, E_actual_taken_i;
  logic [2:0] E_tag_i;
  logic       ED_train_valid_o, ED_train_global_predict_o, ED_train_global_taken_o;
  logic [6:0] ED_train_global_history_o;
  logic       MD_train_valid_o, MD_train_predict_o, MD_train_taken_o;
  logic       MD_train_global_predict_o, MD_train_global_taken_o;
  logic       MD_train_local_predict_o, MD_train_local_taken_o;
  logic [6:0] MD_PC_o, MD_train_global_history_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  branch_train_queue dut (
    .clk_i(clk_i), .rst(rst), .flush_i(flush_i),
    .F_alloc_valid_i(F_alloc_valid_i), .F_PC_i(F_PC_i),
    .F_global_history_i(F_global_history_i), .F_predict_i(F_predict_i),
    .F_global_predict_i(F_global_predict_i), .F_local_predict_i(F_local_predict_i),
    .F_alloc_ready_o(F_alloc_ready_o), .F_tag_o(F_tag_o),
    .E_resolve_valid_i(E_resolve_valid_i), .E_tag_i(E_tag_i),
    .E_actual_taken_i(E_actual_taken_i),
    .ED_train_valid_o(ED_train_valid_o),
    .ED_train_global_history_o(ED_train_global_history_o),
    .ED_train_global_predict_o(ED_train_global_predict_o),
    .ED_train_global_taken_o(ED_train_global_taken_o),
    .MD_train_valid_o(MD_train_valid_o), .MD_PC_o(MD_PC_o),
    .MD_train_global_history_o(MD_train_global_history_o),
    .MD_train_predict_o(MD_train_predict_o), .MD_train_taken_o(MD_train_taken_o),
    .MD_train_global_predict_o(MD_train_global_predict_o),
    .MD_train_global_taken_o(MD_train_global_taken_o),
    .MD_train_local_predict_o(MD_train_local_predict_o),
    .MD_train_local_taken_o(MD_train_local_taken_o)
  );

  typedef struct {
    logic       rs, fl, av;
    logic [6:0] pc;
    logic       pred, rv;
    logic [2:0] tag;
    logic       act;
    logic       exp_rdy;
    logic [2:0] exp_tag;
    logic       exp_ed, exp_edtk, exp_md;
    logic [6:0] exp_mdpc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int rs, input int fl, input int av, input int pc, input int pred,
                     input int rv, input int tag, input int act, input int rdy, input int etag,
                     input int ed, input int edtk, input int md, input int mdpc);
    vec_t v;
    v.rs = 1'(rs); v.fl = 1'(fl); v.av = 1'(av); v.pc = 7'(pc); v.pred = 1'(pred);
    v.rv = 1'(rv); v.tag = 3'(tag); v.act = 1'(act); v.exp_rdy = 1'(rdy);
    v.exp_tag = 3'(etag); v.exp_ed = 1'(ed); v.exp_edtk = 1'(edtk);
    v.exp_md = 1'(md); v.exp_mdpc = 7'(mdpc);
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    flush_i = 0; F_alloc_valid_i = 0; F_PC_i = '0; F_global_history_i = '0;
    F_predict_i = 0; F_global_predict_i = 0; F_local_predict_i = 0;
    E_resolve_valid_i = 0; E_tag_i = '0; E_actual_taken_i = 0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  initial begin
    do_reset();
    check("rst ready", 32'(F_alloc_ready_o), 1);
    check("rst tag", 32'(F_tag_o), 0);
    check("rst ed_valid", 32'(ED_train_valid_o), 0);
    check("rst md_valid", 32'(MD_train_valid_o), 0);
    check("rst md_pc", 32'(MD_PC_o), 0);

    // Single branch from predict through early repair to commit training.
    F_alloc_valid_i = 1; F_PC_i = 7'h12; F_global_history_i = 7'h05;
    F_predict_i = 1; F_global_predict_i = 1; F_local_predict_i = 0;
    tick();
    idle_inputs();
    check("a alloc tag", 32'(F_tag_o), 1);
    E_resolve_valid_i = 1; E_tag_i = 3'd0; E_actual_taken_i = 1;
    tick();
    idle_inputs();
    check("a ed_valid", 32'(ED_train_valid_o), 1);
    check("a ed_hist", 32'(ED_train_global_history_o), 32'h05);
    check("a ed_pred", 32'(ED_train_global_predict_o), 1);
    check("a ed_taken", 32'(ED_train_global_taken_o), 1);
    check("a md early", 32'(MD_train_valid_o), 0);
    tick();
    check("a ed_drop", 32'(ED_train_valid_o), 0);
    check("a md_valid", 32'(MD_train_valid_o), 1);
    check("a md_pc", 32'(MD_PC_o), 32'h12);
    check("a md_hist", 32'(MD_train_global_history_o), 32'h05);
    check("a md_pred", 32'(MD_train_predict_o), 1);
    check("a md_taken", 32'(MD_train_taken_o), 1);
    check("a md_gpred", 32'(MD_train_global_predict_o), 1);
    check("a md_gtaken", 32'(MD_train_global_taken_o), 1);
    check("a md_lpred", 32'(MD_train_local_predict_o), 0);
    check("a md_ltaken", 32'(MD_train_local_taken_o), 0);
    tick();
    check("a md_drop", 32'(MD_train_valid_o), 0);

    do_reset();
    // Fill to full, reject overflow, commit frees a slot.
    for (int i = 0; i < 8; i++) add(0,0,1,i,1, 0,0,0, (i != 7), (i + 1) % 8, 0,0,0,0);
    add(0,0,1,8,1,   0,0,0, 0,0, 0,0,0,0);
    add(0,0,0,0,0,   1,0,1, 0,0, 1,1,0,0);
    add(0,0,1,9,1,   0,0,0, 1,0, 0,0,1,0);
    add(0,0,1,10,1,  0,0,0, 0,1, 0,0,0,0);
    add(0,0,0,0,0,   1,1,1, 0,1, 1,1,0,0);
    add(0,0,0,0,0,   1,1,1, 1,1, 0,0,1,1);
    // Mispredict on tag 1 squashes tags 2..4 and the coincident alloc.
    add(1,0,0,0,0,   0,0,0, 1,0, 0,0,0,0);
    for (int i = 0; i < 5; i++) add(0,0,1,'h10 + i,1, 0,0,0, 1,i + 1, 0,0,0,0);
    add(0,0,1,'h15,1, 1,1,0, 1,2, 1,0,0,0);
    add(0,0,0,0,0,   1,3,1, 1,2, 0,0,0,0);
    add(0,0,0,0,0,   1,0,1, 1,2, 1,1,0,0);
    add(0,0,0,0,0,   0,0,0, 1,2, 0,0,1,'h10);
    add(0,0,0,0,0,   0,0,0, 1,2, 0,0,1,'h11);
    add(0,0,0,0,0,   0,0,0, 1,2, 0,0,0,0);
    add(0,0,1,'h16,1, 0,0,0, 1,3, 0,0,0,0);
    // Out-of-order resolve still commits in order.
    add(1,0,0,0,0,   0,0,0, 1,0, 0,0,0,0);
    for (int i = 0; i < 3; i++) add(0,0,1,'h20 + i,1, 0,0,0, 1,i + 1, 0,0,0,0);
    add(0,0,0,0,0,   1,2,1, 1,3, 1,1,0,0);
    add(0,0,0,0,0,   0,0,0, 1,3, 0,0,0,0);
    add(0,0,0,0,0,   1,0,1, 1,3, 1,1,0,0);
    add(0,0,0,0,0,   1,1,1, 1,3, 1,1,1,'h20);
    add(0,0,0,0,0,   0,0,0, 1,3, 0,0,1,'h21);
    add(0,0,0,0,0,   0,0,0, 1,3, 0,0,1,'h22);
    add(0,0,0,0,0,   0,0,0, 1,3, 0,0,0,0);
    // Flush with five entries and a concurrent alloc/resolve.
    add(1,0,0,0,0,   0,0,0, 1,0, 0,0,0,0);
    for (int i = 0; i < 5; i++) add(0,0,1,'h30 + i,1, 0,0,0, 1,i + 1, 0,0,0,0);
    add(0,0,0,0,0,   1,0,1, 1,5, 1,1,0,0);
    add(0,0,0,0,0,   1,1,1, 1,5, 1,1,1,'h30);
    add(0,1,1,'h35,1, 1,2,1, 1,0, 0,0,0,0);
    add(0,0,0,0,0,   0,0,0, 1,0, 0,0,0,0);
    add(0,0,0,0,0,   1,3,1, 1,0, 0,0,0,0);
    add(0,0,1,'h40,1, 0,0,0, 1,1, 0,0,0,0);
    // Reset mid-traffic; the surviving tag becomes stale.
    add(1,0,0,0,0,   1,0,1, 1,0, 0,0,0,0);
    add(0,0,0,0,0,   1,0,1, 1,0, 0,0,0,0);
    add(0,0,0,0,0,   0,0,0, 1,0, 0,0,0,0);

    foreach (vecs[i]) begin
      rst = vecs[i].rs; flush_i = vecs[i].fl;
      F_alloc_valid_i = vecs[i].av; F_PC_i = vecs[i].pc; F_global_history_i = vecs[i].pc;
      F_predict_i = vecs[i].pred; F_global_predict_i = vecs[i].pred;
      F_local_predict_i = ~vecs[i].pred;
      E_resolve_valid_i = vecs[i].rv; E_tag_i = vecs[i].tag; E_actual_taken_i = vecs[i].act;
      tick();
      check($sformatf("v%0d ready", i), 32'(F_alloc_ready_o), 32'(vecs[i].exp_rdy));
      check($sformatf("v%0d tag", i), 32'(F_tag_o), 32'(vecs[i].exp_tag));
      check($sformatf("v%0d ed_valid", i), 32'(ED_train_valid_o), 32'(vecs[i].exp_ed));
      check($sformatf("v%0d md_valid", i), 32'(MD_train_valid_o), 32'(vecs[i].exp_md));
      if (vecs[i].exp_ed)
        check($sformatf("v%0d ed_taken", i), 32'(ED_train_global_taken_o), 32'(vecs[i].exp_edtk));
      if (vecs[i].exp_md)
        check($sformatf("v%0d md_pc", i), 32'(MD_PC_o), 32'(vecs[i].exp_mdpc));
      if (vecs[i].rs) begin
        check($sformatf("v%0d rst md_pc", i), 32'(MD_PC_o), 0);
        check($sformatf("v%0d rst ed_hist", i), 32'(ED_train_global_history_o), 0);
      end
    end
    rst = 0;
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
